// File: rtl/i2c_target.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, addressed write path with ACK.
// Define I2C_TARGET_READ_EN to add read support; without it read requests are NACKed.
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h42,
  parameter int         SYNC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy
);

`ifdef I2C_TARGET_READ_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_IGNORE
  } state_t;
`endif

  logic [SYNC-1:0] scl_sync_q, sda_sync_q;
  logic            scl_prev_q, sda_prev_q;
  logic            scl_s, sda_s;
  logic            scl_rise, scl_fall, start_det, stop_det;

  state_t          state_q;
  logic [2:0]      cnt_q;
  logic [6:0]      sr_q;
  logic            sda_oe_q;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q;
  logic            busy_q;
  logic [7:0]      byte_in;
  logic            addr_hit;

`ifdef I2C_TARGET_READ_EN
  logic            rw_q;
  logic            tx_load_q;
  logic [6:0]      tx_sr_q;
`else
  logic            tx_data_unused;
  assign tx_data_unused = ^tx_data;
`endif

  // Synchronizers reset to the idle-bus level so release of rst never looks like START/STOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC-2:0], sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC-1];
  assign sda_s     = sda_sync_q[SYNC-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign byte_in   = {sr_q, sda_s};
`ifdef I2C_TARGET_READ_EN
  assign addr_hit  = (byte_in[7:1] == ADDR);
`else
  assign addr_hit  = (byte_in[7:1] == ADDR) && !byte_in[0];
`endif

  // In the ACK states sda_oe_q doubles as the phase flag: 0 = ACK not yet driven, 1 = ACK on bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd7;
      sr_q       <= '0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef I2C_TARGET_READ_EN
      rw_q       <= 1'b0;
      tx_load_q  <= 1'b0;
      tx_sr_q    <= '0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
`ifdef I2C_TARGET_READ_EN
      tx_load_q  <= 1'b0;
`endif
      if (start_det) begin
        state_q  <= S_ADDR;
        cnt_q    <= 3'd7;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (stop_det) begin
        state_q  <= S_IDLE;
        cnt_q    <= 3'd7;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR: begin
            if (scl_rise) begin
              sr_q  <= byte_in[6:0];
              cnt_q <= cnt_q - 3'd1;
              if (cnt_q == 3'd0) begin
                if (addr_hit) begin
                  state_q <= S_ADDR_ACK;
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= S_IGNORE;
                end
`ifdef I2C_TARGET_READ_EN
                rw_q <= byte_in[0];
`endif
              end
            end
          end

          S_ADDR_ACK, S_WR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end
`ifdef I2C_TARGET_READ_EN
              else if (state_q == S_ADDR_ACK && rw_q) begin
                state_q   <= S_RD_DATA;
                cnt_q     <= 3'd7;
                tx_load_q <= 1'b1;
                sda_oe_q  <= ~tx_data[7];
                tx_sr_q   <= tx_data[6:0];
              end
`endif
              else begin
                sda_oe_q <= 1'b0;
                state_q  <= S_WR_DATA;
              end
            end
          end

          S_WR_DATA: begin
            if (scl_rise) begin
              sr_q  <= byte_in[6:0];
              cnt_q <= cnt_q - 3'd1;
              if (cnt_q == 3'd0) begin
                rx_data_q  <= byte_in;
                rx_valid_q <= 1'b1;
                state_q    <= S_WR_ACK;
              end
            end
          end

`ifdef I2C_TARGET_READ_EN
          S_RD_DATA: begin
            if (scl_fall) begin
              cnt_q <= cnt_q - 3'd1;
              if (cnt_q == 3'd0) begin
                sda_oe_q <= 1'b0;
                state_q  <= S_RD_ACK;
              end else begin
                sda_oe_q <= ~tx_sr_q[6];
                tx_sr_q  <= {tx_sr_q[5:0], 1'b0};
              end
            end
          end

          // A fall here can only follow a rise that sampled a master ACK
          S_RD_ACK: begin
            if (scl_rise && sda_s) begin
              state_q <= S_IGNORE;
              busy_q  <= 1'b0;
            end else if (scl_fall) begin
              state_q   <= S_RD_DATA;
              cnt_q     <= 3'd7;
              tx_load_q <= 1'b1;
              sda_oe_q  <= ~tx_data[7];
              tx_sr_q   <= tx_data[6:0];
            end
          end
`endif

          default: begin
          end
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
`ifdef I2C_TARGET_READ_EN
  assign tx_load  = tx_load_q;
`else
  assign tx_load  = 1'b0;
`endif

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter ADDR, default 7'h42: 7-bit target address this block answers to.
REQ-002 SHALL have parameter SYNC, default 2: number of synchronizer flops on scl_in and sda_in, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port scl_in, input, 1 bit: bus SCL level, asynchronous to clk.
REQ-006 SHALL have port sda_in, input, 1 bit: bus SDA level, asynchronous to clk.
REQ-007 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low, 0 releases SDA.
REQ-008 SHALL have port rx_data, output, 8 bits: last received write byte, MSB first on the bus.
REQ-009 SHALL have port rx_valid, output, 1 bit: one-clk pulse when rx_data updates.
REQ-010 SHALL have port tx_data, input, 8 bits: byte to return on a read.
REQ-011 SHALL have port tx_load, output, 1 bit: one-clk pulse when tx_data is captured; user then presents the next byte.
REQ-012 SHALL have port busy, output, 1 bit: high from an addressed START until STOP.

Function
REQ-013 SHALL detect edges only on synchronized scl/sda; the SCL rise/fall event is a one-clk strobe.
REQ-014 SHALL treat an SDA fall while SCL is high as START and an SDA rise while SCL is high as STOP.
REQ-015 SHALL sample SDA on SCL rise and SHALL change sda_oe only on SCL fall.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and IGNORE.
REQ-017 SHALL use a 3-bit bit counter, bytes MSB first, counter 7 down to 0.
REQ-018 In IDLE: START goes to ADDR; SCL edges are ignored.
REQ-019 After 8 address bits, address[7:1]==ADDR goes to ADDR_ACK, with sda_oe=1 from the next SCL fall for one bit.
REQ-020 On address mismatch, SHALL go to IGNORE with sda_oe=0 until START or STOP.
REQ-021 R/W=0: after the ACK bit, go to WR_DATA.
REQ-022 WR_DATA: on the 8th SCL rise, load rx_data, pulse rx_valid once, then ACK as in REQ-019 and return to WR_DATA.
REQ-023 R/W=1: on the SCL fall ending ADDR_ACK, capture tx_data, pulse tx_load, and drive bit7 (sda_oe = ~bit).
REQ-024 RD_DATA: shift out on each SCL fall; after 8 bits release SDA and enter RD_ACK.
REQ-025 RD_ACK: sampled SDA=0 (master ACK) reloads tx_data with tx_load pulse; SDA=1 (NACK) goes to IGNORE.
REQ-026 START in any state (repeated START) SHALL release sda_oe and go to ADDR, counter reset.
REQ-027 STOP in any state SHALL release sda_oe, drop busy and go to IDLE; a partial byte is discarded, no rx_valid.
REQ-028 busy SHALL be 1 in ADDR_ACK through RD_ACK/WR_ACK and in data states, 0 in IDLE/ADDR/IGNORE.
REQ-029 SHALL never drive SCL (no clock stretching).

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, sda_oe=0, rx_data=0, rx_valid=0, tx_load=0, busy=0, counter=7.
REQ-031 Synchronizer flops SHALL reset to 1 (idle bus), so no START/STOP is detected on release.
REQ-032 Reset mid-transfer SHALL release SDA with no further pulses until a new START.

Configuration
REQ-033 Macro I2C_TARGET_READ_EN SHALL gate read support.
REQ-034 With I2C_TARGET_READ_EN defined, reads behave per REQ-023..025.
REQ-035 Without I2C_TARGET_READ_EN, a matching address with R/W=1 SHALL be NACKed (go to IGNORE), tx_load SHALL be tied 0, and the RD states SHALL be absent.

Verification
REQ-036 START, 0x84, 0xA5, 0x3C, STOP -> ACKs on 3 bytes; rx_valid twice with rx_data 0xA5 then 0x3C; busy low after STOP.
REQ-037 START, 0x90 -> no ACK (sda_oe stays 0); following bytes ignored; no rx_valid.
REQ-038 READ_EN: START, 0x85, tx_data=0x5A then 0xC3, master ACK, then NACK -> bus bits 0x5A, 0xC3; tx_load pulses twice; SDA released after NACK.
REQ-039 No READ_EN: START, 0x85 -> NACK; tx_load never pulses.
REQ-040 START, 0x84, 4 bits of 0xFF, STOP -> no rx_valid, IDLE; then START, 0x84, 0x11, repeated START, 0x84, 0x22 -> rx_valid with 0x11 then 0x22.
REQ-041 rst asserted during RD_DATA with sda_oe=1 -> sda_oe=0 asynchronously; no pulses until a new START.
